// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver with scancode FIFO, presented to the CPU as a
// memory-mapped data register, status register and active-low interrupt.
//
// Handshake: rd_data and rd_status are single-cycle strobes asserted by the
// address decoder after the CPU read of the corresponding register has
// completed; there is no ready/backpressure. A pop on an empty FIFO is ignored.
module ps2_kbd #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILT_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       res,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       rd_data,
  input  logic       rd_status,
  output logic [7:0] data_q,
  output logic [7:0] status_q,
  output logic       irq_n
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // ---------------- input conditioning ----------------
  logic          ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          samp_stb;
  logic          samp_bit;

  // Two-flop synchronisers for both open-drain lines (idle high).
  always_ff @(posedge CLOCK_50 or negedge res) begin
    if (!res) begin
      ps2c_s1 <= 1'b1;
      ps2c_s2 <= 1'b1;
      ps2d_s1 <= 1'b1;
      ps2d_s2 <= 1'b1;
    end else begin
      ps2c_s1 <= PS2_CLK;
      ps2c_s2 <= ps2c_s1;
      ps2d_s1 <= PS2_DAT;
      ps2d_s2 <= ps2d_s1;
    end
  end

  // Glitch filter on the clock; a falling filtered edge yields a one-cycle
  // strobe together with the data bit captured at the same instant.
  always_ff @(posedge CLOCK_50 or negedge res) begin
    if (!res) begin
      filt     <= 1'b1;
      filt_cnt <= '0;
      samp_stb <= 1'b0;
      samp_bit <= 1'b1;
    end else begin
      samp_stb <= 1'b0;
      samp_bit <= ps2d_s2;
      if (ps2c_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_CYCLES - 1)) begin
        filt     <= ps2c_s2;
        filt_cnt <= '0;
        samp_stb <= filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // ---------------- frame FSM ----------------
  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          push_set, ferr_set;
  logic          push_pend;
  logic [7:0]    push_byte;

  // FSM state and frame datapath registers.
  always_ff @(posedge CLOCK_50 or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
      push_pend <= 1'b0;
      push_byte <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      par       <= par_n;
      to_cnt    <= to_cnt_n;
      push_pend <= push_set;
      push_byte <= shift;
    end
  end

  // Next-state logic: bit collection, frame check and inactivity timeout.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    push_set  = 1'b0;
    ferr_set  = 1'b0;
    to_cnt_n  = (state == IDLE || samp_stb) ? '0 : to_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (samp_stb && !samp_bit) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (samp_stb) begin
          shift_n   = {samp_bit, shift[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (samp_stb) begin
          par_n   = samp_bit;
          state_n = STOP;
        end
      end
      STOP: begin
        if (samp_stb) begin
          if (samp_bit && (^{shift, par})) push_set = 1'b1;
          else                             ferr_set = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A stalled frame is abandoned; no strobe means the case above changed nothing.
    if (state != IDLE && !samp_stb && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n  = IDLE;
      ferr_set = 1'b1;
    end
  end

  // ---------------- FIFO and register file ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [4:0]    count, count_n;
  logic          overflow, frame_err, ovf_n, ferr_n;
  logic          pop_ok, push_ok, ovf_set;
  logic [7:0]    head_n;

  // Push/pop arbitration and the next-cycle view used by the output registers.
  always_comb begin
    pop_ok   = rd_data && (count != 5'd0);
    push_ok  = push_pend && ((count != 5'(FIFO_DEPTH)) || pop_ok);
    ovf_set  = push_pend && !push_ok;
    count_n  = count + 5'(push_ok) - 5'(pop_ok);
    rd_ptr_n = pop_ok  ? rd_ptr + 1'b1 : rd_ptr;
    wr_ptr_n = push_ok ? wr_ptr + 1'b1 : wr_ptr;
    // The byte being written this cycle is not in mem yet; bypass it.
    head_n   = (push_ok && wr_ptr == rd_ptr_n) ? push_byte : mem[rd_ptr_n];
    ovf_n    = ovf_set  | (overflow  & ~rd_status);
    ferr_n   = ferr_set | (frame_err & ~rd_status);
  end

  // Scancode storage; contents are only visible through count-qualified outputs.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem[wr_ptr] <= push_byte;
  end

  // FIFO pointers, sticky error bits and registered CPU-facing outputs.
  always_ff @(posedge CLOCK_50 or negedge res) begin
    if (!res) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      data_q    <= 8'h00;
      status_q  <= 8'h00;
      irq_n     <= 1'b1;
    end else begin
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      count     <= count_n;
      overflow  <= ovf_n;
      frame_err <= ferr_n;
      data_q    <= (count_n == 5'd0) ? 8'h00 : head_n;
      status_q  <= {count_n != 5'd0, ovf_n, ferr_n, count_n};
      irq_n     <= (count_n == 5'd0);
    end
  end

endmodule

// File: tb/tb_ps2_kbd.sv
// Directed bench for ps2_kbd: valid frames, parity error, overflow,
// coincident push/pop, timeout, clock glitches and asynchronous reset.
// The PS/2 clock and timeout are scaled down to keep the run short.
module tb_ps2_kbd;

  localparam int H       = 40;    // PS/2 half period in system clocks
  localparam int TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_data = 1'b0;
  logic       rd_status = 1'b0;
  logic [7:0] data_q, status_q;
  logic       irq_n;

  int n_cmp = 0;
  int n_err = 0;

  ps2_kbd #(
    .FIFO_DEPTH(8),
    .FILT_CYCLES(8),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLOCK_50(clk),
    .res(res),
    .PS2_CLK(ps2_clk),
    .PS2_DAT(ps2_dat),
    .rd_data(rd_data),
    .rd_status(rd_status),
    .data_q(data_q),
    .status_q(status_q),
    .irq_n(irq_n)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Frame vector, bit 0 first on the wire: start, data LSB-first, odd parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      repeat (H / 2) @(negedge clk);
      if (glitch) begin
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (H / 2 - 3) @(negedge clk);
      end else begin
        repeat (H / 2) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0), 11, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_rd_data();
    rd_data = 1'b1;
    @(negedge clk);
    rd_data = 1'b0;
  endtask

  task automatic pulse_rd_status();
    rd_status = 1'b1;
    @(negedge clk);
    rd_status = 1'b0;
  endtask

  // Bounded wait for the internal sample strobe; returns at the cycle it is high.
  task automatic wait_stb(output logic found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (dut.samp_stb) found = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    logic [10:0] f;

    #35;
    check("rst_data", data_q, 8'h00);
    check("rst_status", status_q, 8'h00);
    check("rst_irq", {7'b0, irq_n}, 8'h01);
    res = 1'b1;
    repeat (20) @(negedge clk);

    // 1: single 8'h1C frame with exact latency from the stop strobe
    f = make_frame(8'h1C, 1'b0);
    send_bits(f, 10, 1'b0);
    ps2_dat = f[10];
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    wait_stb(found);
    check("stop_stb_seen", {7'b0, found}, 8'h01);
    @(negedge clk);
    check("lat1_irq", {7'b0, irq_n}, 8'h01);
    @(negedge clk);
    check("lat2_irq", {7'b0, irq_n}, 8'h00);
    check("lat2_data", data_q, 8'h1C);
    check("lat2_status", status_q, 8'h81);
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    pulse_rd_data();
    check("pop1_status", status_q, 8'h00);
    check("pop1_data", data_q, 8'h00);
    check("pop1_irq", {7'b0, irq_n}, 8'h01);

    // 2: parity error
    send_bits(make_frame(8'h1C, 1'b1), 11, 1'b0);
    repeat (4) @(negedge clk);
    check("par_status", status_q, 8'h20);
    check("par_irq", {7'b0, irq_n}, 8'h01);
    pulse_rd_status();
    check("par_clr", status_q, 8'h00);

    // 3: overflow, ninth byte lost
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    check("ovf_status", status_q, 8'hC8);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_read", data_q, 8'(i));
      pulse_rd_data();
    end
    check("ovf_empty_status", status_q, 8'h40);
    check("ovf_empty_data", data_q, 8'h00);
    pulse_rd_data();
    check("pop_empty_status", status_q, 8'h40);
    pulse_rd_status();
    check("ovf_clr", status_q, 8'h00);

    // 4: full FIFO, ninth push coincides with a pop
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("full_status", status_q, 8'h88);
    f = make_frame(8'h09, 1'b0);
    send_bits(f, 10, 1'b0);
    ps2_dat = f[10];
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    wait_stb(found);
    check("co_stb_seen", {7'b0, found}, 8'h01);
    @(negedge clk);
    pulse_rd_data();
    check("co_status", status_q, 8'h88);
    check("co_head", data_q, 8'h02);
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 2; i <= 9; i++) begin
      check("co_read", data_q, 8'(i));
      pulse_rd_data();
    end
    check("co_end_status", status_q, 8'h00);

    // 5: clock stalls after four data bits
    send_bits(make_frame(8'hA5, 1'b0), 5, 1'b0);
    repeat (TIMEOUT + TIMEOUT / 10) @(negedge clk);
    check("to_status", status_q, 8'h20);
    check("to_idle", {6'b0, dut.state}, 8'h00);
    pulse_rd_status();
    check("to_clr", status_q, 8'h00);
    send_byte(8'hF0);
    check("to_next_data", data_q, 8'hF0);
    check("to_next_status", status_q, 8'h81);
    pulse_rd_data();
    check("to_pop_status", status_q, 8'h00);

    // 6: short clock glitches are filtered out
    send_bits(make_frame(8'h5A, 1'b0), 11, 1'b1);
    repeat (4) @(negedge clk);
    check("gl_data", data_q, 8'h5A);
    check("gl_status", status_q, 8'h81);

    // 7: asynchronous reset in the middle of a frame
    send_bits(make_frame(8'h33, 1'b0), 4, 1'b0);
    repeat (H / 2) @(negedge clk);
    #3 res = 1'b0;
    #1;
    check("ar_data", data_q, 8'h00);
    check("ar_status", status_q, 8'h00);
    check("ar_irq", {7'b0, irq_n}, 8'h01);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    res = 1'b1;
    repeat (20) @(negedge clk);
    check("ar_after_status", status_q, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_kbd.md
Name: ps2_kbd

Overview:
PS/2 keyboard receiver and memory-mapped input port. It feeds the 6502 data-bus input mux alongside the RAM and ROM. The block deserialises PS/2 device-to-host frames, validates them, and buffers scancodes in a small FIFO. It exposes a data register and a status register to the address decoder, and drives an active-low interrupt request to the CPU.

Parameters:
FIFO_DEPTH, 8, scancode FIFO entries; power of two, range 2..16
FILT_CYCLES, 8, consecutive equal CLOCK_50 samples needed before filtered PS2_CLK changes state
TIMEOUT_CYCLES, 50000, CLOCK_50 cycles (1 ms) without a falling PS2_CLK edge mid-frame before the frame is aborted

Ports:
CLOCK_50  input  1  system clock, 50 MHz; the only clock
res  input  1  reset, asynchronous, active-low
PS2_CLK  input  1  keyboard clock, asynchronous, open-drain
PS2_DAT  input  1  keyboard data, asynchronous, open-drain
rd_data  input  1  one-cycle pulse: CPU read of the data register completed; pops the FIFO
rd_status  input  1  one-cycle pulse: CPU read of the status register completed; clears the sticky error bits
data_q  output  8  scancode at the FIFO head; 8'h00 when the FIFO is empty
status_q  output  8  bit7 avail, bit6 overflow, bit5 frame_err, bits4:0 FIFO count (saturates at 31)
irq_n  output  1  low while the FIFO is not empty

Behaviour:
- Reset (res low, asynchronous): FSM to IDLE; FIFO empty; sticky bits cleared; filters to 1; data_q=8'h00; status_q=8'h00; irq_n=1.
- Input conditioning:
  - PS2_CLK and PS2_DAT each pass a 2-flop synchroniser.
  - PS2_CLK then passes the glitch filter: the filtered value changes only after FILT_CYCLES identical consecutive samples.
  - A falling edge of the filtered clock produces a one-cycle sample strobe. PS2_DAT (synchronised) is sampled on that strobe.
- Frame format: 11 bits.
  - Start bit = 0, then 8 data bits LSB first, then odd parity, then stop bit = 1.
- FSM states and transitions (all on the sample strobe unless noted):
  - IDLE: sampled 0 → DATA with bit count 0. Sampled 1 → stay in IDLE (line noise ignored; no error).
  - DATA: shift the bit in LSB-first. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: check the frame, then → IDLE.
    - Stop bit = 1 and data bits plus parity have an odd count of ones → push the byte.
    - Otherwise → discard the byte and set frame_err.
  - Timeout: in DATA, PARITY or STOP, TIMEOUT_CYCLES without a strobe → discard the partial frame, set frame_err, go to IDLE. The timeout counter clears on every strobe and in IDLE.
- FIFO:
  - Push occurs in the cycle after the STOP strobe.
  - Push when full → byte dropped, overflow set, contents unchanged.
  - rd_data when empty → no effect.
  - Simultaneous push and pop:
    - Both succeed; count is unchanged.
    - When full, the pop frees the slot and the push is accepted with no overflow.
    - When empty, only the push takes effect and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Outputs:
  - data_q, status_q and irq_n are registered and reflect the FIFO state one cycle after any push or pop.
  - data_q shows the new head one cycle after a pop.
- Sticky bits: overflow and frame_err clear on rd_status. If a set event occurs in the same cycle as rd_status, the set wins.
- Latency: avail=1 and irq_n=0 exactly 2 CLOCK_50 cycles after the STOP sample strobe.

Test Plan:
- Send frame for 8'h1C (start 0, data LSB-first, parity 0, stop 1) at 10 kHz PS2 clock → 2 cycles after STOP strobe: data_q=8'h1C, status_q=8'h81, irq_n=0. Pulse rd_data → status_q=8'h00, data_q=8'h00, irq_n=1.
- Send 8'h1C with parity bit inverted → FIFO stays empty, status_q=8'h20. Pulse rd_status → status_q=8'h00.
- Send 9 valid frames (8'h01..8'h09) with no reads, FIFO_DEPTH=8 → status_q=8'hC8. Eight rd_data pulses return 8'h01..8'h08 in order; 8'h09 is lost.
- FIFO full, 9th frame's push coincides with an rd_data pulse → no overflow, count stays 8, final read order is 8'h02..8'h09.
- Stop PS2_CLK after 4 data bits for 1.1 ms → frame_err set, FSM in IDLE. A following valid 8'hF0 frame is received correctly.
- Inject 3-cycle low glitches on PS2_CLK between edges → no extra bits are sampled, and 8'h5A is received intact. Assert res mid-frame → all outputs return to reset values immediately.
